reg_file_mp: RTL and testbench

//   Parametrised successor to the CPU's 8x16 register file. Provides 2 async read ports
//   and 2 write ports, plus optional write-to-read bypass and an optional hardwired-zero R0.

---
 rtl/reg_file_mp.sv | 101 ++++++++++
 tb/tb_reg_file_mp.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with bypass, optional zero R0 and busy scoreboard
module reg_file_mp #(
    parameter int DATA_W  = 16,
    parameter int NREGS   = 8,
    parameter int ADDR_W  = 3,
    parameter bit ZERO_R0 = 1'b0,
    parameter bit BYPASS  = 1'b1,
    parameter int DBG_REG = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [DATA_W-1:0] rd0,
    output logic [DATA_W-1:0] rd1,
    input  logic              bset,
    input  logic [ADDR_W-1:0] bset_a,
    output logic              busy0,
    output logic              busy1,
    output logic [NREGS-1:0]  busy_vec,
    output logic [DATA_W-1:0] dbg_out
);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;

    logic w_we0;
    logic w_we1;
    logic w_bset;

    // Writes and busy-sets aimed at a hardwired R0 are dropped before they reach storage.
    assign w_we0  = we0  && !(ZERO_R0 && (wa0 == '0));
    assign w_we1  = we1  && !(ZERO_R0 && (wa1 == '0));
    assign w_bset = bset && !(ZERO_R0 && (bset_a == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_we1 && (wa1 == ADDR_W'(i))) begin
                    r_regs[i] <= wd1;
                end else if (w_we0 && (wa0 == ADDR_W'(i))) begin
                    r_regs[i] <= wd0;
                end
                // A new pending write issued this cycle outranks the one retiring.
                if (w_bset && (bset_a == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if ((we0 && (wa0 == ADDR_W'(i))) || (we1 && (wa1 == ADDR_W'(i)))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              rst,
        input logic              e0,
        input logic [ADDR_W-1:0] a0,
        input logic [DATA_W-1:0] d0,
        input logic              e1,
        input logic [ADDR_W-1:0] a1,
        input logic [DATA_W-1:0] d1
    );
        logic [DATA_W-1:0] v;
        v = stored;
        if (BYPASS && !rst) begin
            if (e1 && (a1 == a)) begin
                v = d1;
            end else if (e0 && (a0 == a)) begin
                v = d0;
            end
        end
        if (ZERO_R0 && (a == '0)) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        rd0 = read_port(ra0, r_regs[ra0], reset, we0, wa0, wd0, we1, wa1, wd1);
        rd1 = read_port(ra1, r_regs[ra1], reset, we0, wa0, wd0, we1, wa1, wd1);
    end

    assign busy0    = r_busy[ra0];
    assign busy1    = r_busy[ra1];
    assign busy_vec = r_busy;
    assign dbg_out  = r_regs[DBG_REG];

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for reg_file_mp
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        we0, we1, bset;
    logic [2:0]  wa0, wa1, ra0, ra1, bset_a;
    logic [15:0] wd0, wd1;

    logic [15:0] a_rd0, a_rd1, a_dbg, b_rd0, b_rd1, b_dbg, z_rd0, z_rd1, z_dbg;
    logic        a_b0, a_b1, b_b0, b_b1, z_b0, z_b1;
    logic [7:0]  a_bv, b_bv, z_bv;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    reg_file_mp u_dut (
        .clk(clk), .reset(reset), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .ra0(ra0), .ra1(ra1),
        .rd0(a_rd0), .rd1(a_rd1), .bset(bset), .bset_a(bset_a),
        .busy0(a_b0), .busy1(a_b1), .busy_vec(a_bv), .dbg_out(a_dbg)
    );

    reg_file_mp #(.BYPASS(1'b0)) u_nobyp (
        .clk(clk), .reset(reset), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .ra0(ra0), .ra1(ra1),
        .rd0(b_rd0), .rd1(b_rd1), .bset(bset), .bset_a(bset_a),
        .busy0(b_b0), .busy1(b_b1), .busy_vec(b_bv), .dbg_out(b_dbg)
    );

    reg_file_mp #(.ZERO_R0(1'b1)) u_zero (
        .clk(clk), .reset(reset), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .ra0(ra0), .ra1(ra1),
        .rd0(z_rd0), .rd1(z_rd1), .bset(bset), .bset_a(bset_a),
        .busy0(z_b0), .busy1(z_b1), .busy_vec(z_bv), .dbg_out(z_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; bset = 0;
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; bset_a = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1; ra0 = 0; ra1 = 0;
        tick();
        reset = 0;

        // preload everything with FFFF and mark several registers busy
        for (int i = 0; i < 4; i++) begin
            we0 = 1; wa0 = 3'(2 * i);     wd0 = 16'hFFFF;
            we1 = 1; wa1 = 3'(2 * i + 1); wd1 = 16'hFFFF;
            bset = 1; bset_a = 3'(i + 1);
            tick();
        end
        idle();
        ra0 = 1;
        #1 check("preload_r1", a_rd0, 16'hFFFF);
        check("preload_busy", a_bv, 8'h1E);

        // reset overrides writes and bset; bypass is suppressed while reset is high
        reset = 1;
        we0 = 1; wa0 = 2; wd0 = 16'h1111; bset = 1; bset_a = 6; ra0 = 2;
        #1 check("reset_no_bypass", a_rd0, 16'hFFFF);
        tick();
        reset = 0;
        idle();
        for (int i = 0; i < 8; i++) begin
            ra0 = 3'(i); ra1 = 3'(7 - i);
            #1 check($sformatf("reset_rd0_r%0d", i), a_rd0, 16'h0000);
            check($sformatf("reset_rd1_r%0d", 7 - i), a_rd1, 16'h0000);
        end
        check("reset_busy_vec", a_bv, 8'h00);
        check("reset_dbg", a_dbg, 16'h0000);

        // dual write to different registers
        we0 = 1; wa0 = 2; wd0 = 16'h1234;
        we1 = 1; wa1 = 5; wd1 = 16'hBEEF;
        tick();
        idle();
        ra0 = 2; ra1 = 5;
        #1 check("dual_rd0", a_rd0, 16'h1234);
        check("dual_rd1", a_rd1, 16'hBEEF);
        check("dual_nobyp_rd0", b_rd0, 16'h1234);
        check("dual_nobyp_rd1", b_rd1, 16'hBEEF);

        // collision: port 1 wins, in the bypass path and in storage
        we0 = 1; wa0 = 3; wd0 = 16'hAAAA;
        we1 = 1; wa1 = 3; wd1 = 16'h5555;
        ra1 = 3;
        #1 check("collide_bypass", a_rd1, 16'h5555);
        tick();
        idle();
        ra0 = 3;
        #1 check("collide_store", a_rd0, 16'h5555);
        check("collide_store_nobyp", b_rd0, 16'h5555);

        // bypass vs no bypass
        we0 = 1; wa0 = 4; wd0 = 16'h0001;
        tick();
        we0 = 1; wa0 = 4; wd0 = 16'h00F0; ra0 = 4;
        #1 check("bypass_on", a_rd0, 16'h00F0);
        check("bypass_off", b_rd0, 16'h0001);
        tick();
        idle();
        #1 check("bypass_off_after", b_rd0, 16'h00F0);

        // scoreboard set / set-beats-clear / clear
        bset = 1; bset_a = 6;
        tick();
        idle();
        ra0 = 6;
        #1 check("busy_set_vec", a_bv, 8'h40);
        check("busy_set_b0", a_b0, 1'b1);
        bset = 1; bset_a = 6; we1 = 1; wa1 = 6; wd1 = 16'h0606;
        tick();
        idle();
        #1 check("busy_set_wins", a_bv, 8'h40);
        we0 = 1; wa0 = 6; wd0 = 16'h0660;
        #1 check("busy_not_bypassed", a_b0, 1'b1);
        tick();
        idle();
        #1 check("busy_cleared", a_bv, 8'h00);
        check("busy_cleared_b0", a_b0, 1'b0);

        // hardwired R0 versus normal R0
        we0 = 1; wa0 = 0; wd0 = 16'h7777; bset = 1; bset_a = 0; ra0 = 0; ra1 = 0;
        #1 check("zero_r0_wcycle", z_rd0, 16'h0000);
        check("normal_r0_bypass", a_rd0, 16'h7777);
        tick();
        idle();
        #1 check("zero_r0_after", z_rd0, 16'h0000);
        check("zero_r0_busy", z_bv, 8'h00);
        check("normal_r0_store", a_rd1, 16'h7777);
        check("normal_r0_busy", a_bv, 8'h01);

        // dbg_out mirrors stored R7 one cycle after the write
        we1 = 1; wa1 = 7; wd1 = 16'hCAFE;
        #1 check("dbg_before", a_dbg, 16'h0000);
        tick();
        idle();
        #1 check("dbg_after", a_dbg, 16'hCAFE);
        check("dbg_after_zero", z_dbg, 16'hCAFE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
